uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel UART receiver, 8N1, fixed baud, for the debug UART path. It samples the asynchronous RX pin and recovers bytes, checking the stop bit on each one. Each byte goes to the consumer over a valid/ready handshake. It is the receive-side counterpart of the debug transmitter, shares its 27 MHz clock and 115200-baud divisor, and supports loopback testing of that transmitter.

## Interface
- BAUD_DIVISOR, 234: clock cycles per bit (27 MHz / 115200); legal range 4..65535.
- HALF_DIV, BAUD_DIVISOR/2 (integer division): cycles from start-bit detection to start-bit mid-point sample.

- clk  input  1  system clock, 27 MHz; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: unconsumed byte overwritten.

## Operation
- Synchronizer: two flops (sync1 → sync2), both reset to 1; all decisions use sync2 only.
- Counters: baud counter 16 bits, counts 0..limit-1 then reloads 0; bit index 3 bits; shift register 8 bits, LSB received first, shifted in from the MSB side.
- States:
  - IDLE: on sync2==0, go to START and clear the counter.
  - START: at count HALF_DIV-1, sample sync2. If 0, go to DATA with bit index 0. If 1 (glitch), go back to IDLE with no output.
  - DATA: every BAUD_DIVISOR cycles, sample sync2 into the shift register. After bit index 7, go to STOP.
  - STOP: after BAUD_DIVISOR cycles, sample sync2.
    - If 1: load rx_data from the shift register, set rx_valid, go to IDLE.
    - If 0: pulse frame_err, leave rx_data and rx_valid unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until sync2==1, then go to IDLE (resyncs after a break or misframe).
  - Any unused encoding goes to IDLE.
- Handshake:
  - rx_valid clears on the edge where rx_valid && rx_ready, unless a new byte is delivered on the same edge.
  - If a new byte is delivered while rx_valid=1 and rx_ready=0: overwrite rx_data, keep rx_valid=1, pulse overrun.
  - If a new byte is delivered on the same edge as a consume: load the new byte, keep rx_valid=1, no overrun.
- Reset:
  - Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, state=IDLE, counters=0, sync flops=1.
  - Reset mid-frame discards the partial byte.
  - A line still low after reset is treated as a new start bit. Any resulting stop-bit failure is reported through frame_err/WAIT_IDLE.

## Timing
- Input latency: a pin change is visible on sync2 2 cycles later.
- t0 is the edge at which IDLE sees sync2==0.
- Sample edges:
  - Start bit: t0+HALF_DIV.
  - Data bit k (k=0..7): t0+HALF_DIV+(k+1)·BAUD_DIVISOR.
  - Stop bit: t0+HALF_DIV+9·BAUD_DIVISOR.
- rx_valid, rx_data, frame_err and overrun are registered at the stop-sample edge and visible in the following cycle.
- frame_err and overrun are high for exactly one cycle.
- The receiver is back in IDLE one cycle after the stop sample. A start bit immediately following the stop bit is therefore caught, with at most 1 cycle plus synchronizer delay of skew.
- Throughput: back-to-back frames are accepted continuously at the line rate.
- rx_ready is examined only on edges where rx_valid=1. It may be held high permanently.

## Test plan
- Reset, line high, send 0x41 at BAUD_DIVISOR=234 with rx_ready=0 → rx_data=0x41 and rx_valid=1 from t0+117+9·234+1 (t0+2224). rx_valid held until rx_ready=1, then clears the next cycle.
- Back-to-back 0x55, 0x0D, 0x0A with no idle gap, rx_ready tied 1 → three rx_valid deliveries with those values in order; frame_err=0, overrun=0.
- Low glitch on uart_rx lasting 50 cycles (< HALF_DIV) → START returns to IDLE; no rx_valid, no frame_err. A valid 0xA5 sent afterwards is received correctly.
- Frame 0x3C with stop bit held low, line then held low for 3 bit times → one frame_err pulse; rx_valid stays 0; state stays WAIT_IDLE until the line goes high. The next frame 0x7E is received.
- Send 0x11 then 0x22 with rx_ready=0 → rx_data=0x22, rx_valid=1, one overrun pulse at the second delivery.
- Repeat the 0x11/0x22 sequence with rx_ready pulsed on the second delivery edge → rx_data=0x22, rx_valid=1, no overrun.
- Assert reset for 1 cycle during data bit 4 of a frame → all outputs at reset values; no byte delivered for the interrupted frame. A following 0x0D frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, stop-bit check and a
// single-entry valid/ready output register with overrun and framing-error pulses.
module uart_receiver #(
  parameter int unsigned BAUD_DIVISOR = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF_DIV = BAUD_DIVISOR / 2;
  localparam logic [15:0] BaudLast = 16'(BAUD_DIVISOR - 1);
  localparam logic [15:0] HalfLast = 16'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        deliver;

  // Frame FSM: all decisions are taken on the synchronized line only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (!sync2_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d   = StData;
            bit_idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == BaudLast) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == BaudLast) begin
          cnt_d = '0;
          if (sync2_q) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StWaitIdle: begin
        if (sync2_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output register: a delivery on the consume edge wins and is not an overrun.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level scoreboard of expected deliveries and error pulses,
// compared every cycle, plus literal checks of bytes, pulse counts and first-byte latency.
module tb_uart_receiver;

  localparam int B    = 234;
  localparam int HALF = B / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  uart_receiver #(.BAUD_DIVISOR(B)) dut (
    .clk       (clk),
    .reset     (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [7:0] d;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] acc[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;
  int         n_rise = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A frame whose start bit is driven now is seen by the receiver 3 edges later (t0);
  // its stop bit is sampled at t0 + HALF + 9 bit times.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int rst_bit);
    evq.push_back('{cyc + 3 + HALF + 9 * B, d, stop_ok});
    uart_rx = 1'b0;
    tick(B);
    for (int k = 0; k < 8; k++) begin
      uart_rx = d[k];
      if (k == rst_bit) begin
        tick(B / 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(B - B / 2 - 1);
      end else begin
        tick(B);
      end
    end
    if (stop_ok) begin
      uart_rx = 1'b1;
      tick(B);
    end else begin
      uart_rx = 1'b0;
      tick(4 * B);
      uart_rx = 1'b1;
    end
  endtask

  // Reference model at frame level: scheduled deliveries plus the valid/ready rules.
  always @(posedge clk) begin
    if (rx_valid && rx_ready) acc.push_back(rx_data);
    cyc <= cyc + 1;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      evq.delete();
    end else begin
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (m_valid && rx_ready) m_valid <= 1'b0;
      if (evq.size() != 0 && evq[0].e == cyc + 1) begin
        if (evq[0].ok) begin
          m_data  <= evq[0].d;
          m_valid <= 1'b1;
          m_ovr   <= m_valid && !rx_ready;
        end else begin
          m_ferr <= 1'b1;
        end
        evq.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      chk("cycle_outputs", {21'd0, rx_valid, rx_data, frame_err, overrun},
          {21'd0, m_valid, m_data, m_ferr, m_ovr});
      if (rx_valid && !prev_valid) begin
        n_rise++;
        rise_cyc = cyc;
      end
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      prev_valid = rx_valid;
    end
  end

  initial begin
    int c0, e2, r0, f0, o0;
    rst      = 1'b1;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    tick(5);
    chk("reset_values", {rx_valid, rx_data, frame_err, overrun}, 11'd0);
    rst = 1'b0;
    tick(10);

    // Single byte, held until consumed; first valid 2 sync + 1 + 117 + 9*234 edges after drive.
    c0 = cyc;
    send_frame(8'h41, 1'b1, -1);
    chk("latency_0x41", rise_cyc - c0, 2226);
    chk("data_0x41", rx_data, 8'h41);
    tick(20);
    chk("valid_held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("valid_cleared", rx_valid, 1'b0);

    // Back-to-back frames, consumer always ready.
    rx_ready = 1'b1;
    acc.delete();
    f0 = n_ferr;
    o0 = n_ovr;
    send_frame(8'h55, 1'b1, -1);
    send_frame(8'h0D, 1'b1, -1);
    send_frame(8'h0A, 1'b1, -1);
    tick(B);
    chk("b2b_count", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b_byte0", acc[0], 8'h55);
      chk("b2b_byte1", acc[1], 8'h0D);
      chk("b2b_byte2", acc[2], 8'h0A);
    end
    chk("b2b_no_ferr", n_ferr - f0, 0);
    chk("b2b_no_ovr", n_ovr - o0, 0);
    rx_ready = 1'b0;

    // Short low glitch is rejected at the start-bit midpoint.
    r0 = n_rise;
    f0 = n_ferr;
    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(3 * B);
    chk("glitch_no_valid", n_rise - r0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);
    send_frame(8'hA5, 1'b1, -1);
    chk("data_0xa5", {rx_valid, rx_data}, {1'b1, 8'hA5});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // Stop bit low, then line low for three more bit times.
    f0 = n_ferr;
    r0 = n_rise;
    send_frame(8'h3C, 1'b0, -1);
    chk("ferr_one_pulse", n_ferr - f0, 1);
    chk("ferr_no_valid", n_rise - r0, 0);
    tick(2 * B);
    send_frame(8'h7E, 1'b1, -1);
    chk("data_0x7e", {rx_valid, rx_data}, {1'b1, 8'h7E});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // Second byte overwrites an unconsumed first byte.
    o0 = n_ovr;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    chk("ovr_one_pulse", n_ovr - o0, 1);
    chk("ovr_data", {rx_valid, rx_data}, {1'b1, 8'h22});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(B);

    // Same sequence, consume exactly on the second delivery edge.
    o0 = n_ovr;
    c0 = cyc;
    e2 = c0 + 3 + HALF + 9 * B + 10 * B;
    fork
      begin
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
      end
      begin
        while (cyc < e2 - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    chk("pulse_no_ovr", n_ovr - o0, 0);
    chk("pulse_data", {rx_valid, rx_data}, {1'b1, 8'h22});
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;

    // Reset during data bit 4 discards the partial frame.
    r0 = n_rise;
    send_frame(8'hF0, 1'b1, 4);
    chk("rst_mid_no_valid", n_rise - r0, 0);
    chk("rst_mid_outputs", {rx_valid, rx_data, frame_err, overrun}, 11'd0);
    tick(B);
    send_frame(8'h0D, 1'b1, -1);
    chk("data_after_rst", {rx_valid, rx_data}, {1'b1, 8'h0D});

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
